// File: rtl/matrix_run_streamer.sv
// matrix_run_streamer: host-side sequencer for the processor's St/done/result
// interface. Fires a one-cycle St pulse, waits (with a watchdog) for done,
// snapshots the WIDTH x WIDTH result matrix and streams it out row-major over
// a valid/ready handshake.
module matrix_run_streamer #(
   parameter  int WIDTH_BIT = 2,
   parameter  int TIMEOUT   = 1024,
   localparam int WIDTH     = 2 ** WIDTH_BIT
) (
   input  logic                                    CLK,
   input  logic                                    RST,
   input  logic                                    go,
   output logic                                    St,
   input  logic                                    done,
   input  logic [0:WIDTH-1][0:WIDTH-1][31:0]       result,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [31:0]                             out_data,
   output logic [WIDTH_BIT-1:0]                    out_row,
   output logic [WIDTH_BIT-1:0]                    out_col,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    timeout
);

   localparam int IW = 2 * WIDTH_BIT;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_STREAM
   } state_e;

   state_e                           state_q, state_d;
   logic                             st_q, st_d;
   logic                             valid_q, valid_d;
   logic [31:0]                      data_q, data_d;
   logic                             last_q, last_d;
   logic                             busy_q, busy_d;
   logic                             timeout_q, timeout_d;
   logic [IW-1:0]                    idx_q, idx_d;
   logic [IW-1:0]                    nxt_idx;
   logic [TW-1:0]                    timer_q, timer_d;
   logic                             capture;
   logic [0:WIDTH-1][0:WIDTH-1][31:0] snap_q;

   // Next-state and next-output logic for the run sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      st_d      = 1'b0;
      valid_d   = valid_q;
      data_d    = data_q;
      last_d    = last_q;
      timeout_d = timeout_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      capture   = 1'b0;
      nxt_idx   = idx_q + IW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d   = S_START;
               st_d      = 1'b1;
               timeout_d = 1'b0;
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done wins over the watchdog when both land in the same cycle
            if (done) begin
               capture = 1'b1;
               idx_d   = '0;
               valid_d = 1'b1;
               data_d  = result[0][0];
               last_d  = 1'b0;
               state_d = S_STREAM;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_STREAM: begin
            if (out_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d  = nxt_idx;
                  data_d = snap_q[nxt_idx[IW-1:WIDTH_BIT]][nxt_idx[WIDTH_BIT-1:0]];
                  last_d = (nxt_idx == {IW{1'b1}});
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Sequencer state and registered outputs, synchronous reset.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (RST) begin
         state_q   <= S_IDLE;
         st_q      <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         idx_q     <= '0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         st_q      <= st_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
      end
   end

   // Snapshot of the result matrix, taken in the cycle done is sampled.
   always_ff @(posedge CLK) begin
      // NOTE: the snapshot buffer is deliberately not reset; it is always written before it is read.
      if (capture) snap_q <= result;
   end

   assign St        = st_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_row   = idx_q[IW-1:WIDTH_BIT];
   assign out_col   = idx_q[WIDTH_BIT-1:0];
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;

endmodule
